pc_reg_unit: RTL and testbench
==============================

Name: pc_reg_unit

Overview:
- Program-counter register stage of the single-cycle RV32I core. It sits directly upstream and downstream of pc_four.
- Drives o_pc into pc_four and instruction memory. Consumes pc_four's o_pc_four and the ALU branch/jump target to select the next PC.
- Adds boot sequencing, stall, halt, misaligned-target trap and a retired-instruction counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned redirect.

Ports:
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_pc_four  input  32  sequential next PC, taken from pc_four o_pc_four (o_pc + 4).
- i_alu_data  input  32  branch/jump target from the ALU.
- i_pc_sel  input  1  1 = take the redirect to i_alu_data; 0 = sequential.
- i_stall  input  1  hold the PC this cycle.
- i_halt_req  input  1  enter HALT (ebreak/ecall from decode).
- o_pc  output  32  current PC.
- o_pc_valid  output  1  o_pc is a fetchable instruction address.
- o_misalign  output  1  one-cycle pulse when a misaligned target is trapped.
- o_mis_addr  output  32  captured offending target.
- o_halted  output  1  core is halted.
- o_instr_cnt  output  32  retired-instruction count.

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=BOOT, o_pc=RESET_VECTOR, o_pc_valid=0, o_misalign=0, o_mis_addr=0, o_halted=0, o_instr_cnt=0. Reset asserted mid-operation overrides every state immediately.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one clock after reset deassertion; PC is held. BOOT->RUN unconditionally. All inputs are ignored in BOOT.
- RUN: o_pc_valid=1. Per rising edge, in priority order:
  1. i_halt_req=1: go to HALT; PC held; counter += 1 (the halting instruction retires).
  2. i_stall=1: PC and counter held. A redirect asserted in the same cycle is not latched; upstream keeps i_pc_sel asserted until the stall drops.
  3. i_pc_sel=1 and i_alu_data[1:0]==2'b00: o_pc <= i_alu_data; counter += 1.
  4. i_pc_sel=1 and i_alu_data[1:0]!=2'b00: o_pc <= TRAP_VECTOR; o_mis_addr <= i_alu_data; o_misalign=1 for exactly the next cycle; counter += 1. Remain in RUN.
  5. Otherwise: o_pc <= i_pc_four; counter += 1.
- HALT: o_pc frozen, o_pc_valid=0, o_halted=1, counter frozen. All inputs are ignored. Exit only via reset.
- Width and arithmetic:
  - The PC is taken verbatim from i_pc_four with no internal check. 0xFFFF_FFFC -> 0x0000_0000 wrap is legal and is not a trap.
  - o_instr_cnt wraps 0xFFFF_FFFF -> 0 silently.
  - o_mis_addr holds its value until the next misaligned redirect or reset.
- Latency: a redirect or sequential update is visible on o_pc one clock after the edge that samples it. No combinational path exists from any input to o_pc, o_pc_valid or o_halted.

Test Plan:
- Boot/sequential: release reset with RESET_VECTOR=0, i_pc_four driven by a pc_four instance, i_pc_sel=0 -> o_pc 0x0 for 2 cycles (o_pc_valid=0 for the first), then 0x4, 0x8, 0xC; o_instr_cnt=3 after the third advance.
- Aligned branch: at o_pc=0x10, i_pc_sel=1, i_alu_data=0x200 -> next o_pc=0x200, then 0x204; o_misalign stays 0.
- Misaligned jump: i_pc_sel=1, i_alu_data=0x0000_0123 -> o_pc=0x100, o_misalign high exactly one cycle, o_mis_addr=0x123.
- Stall vs redirect: i_stall=1 and i_pc_sel=1 (target 0x400) for 3 cycles at o_pc=0x20 -> o_pc stays 0x20 and the counter is unchanged. Drop i_stall with i_pc_sel still 1 -> o_pc=0x400.
- Halt and wrap: drive o_pc to 0xFFFF_FFFC via a redirect -> next o_pc=0x0. Then assert i_halt_req -> o_halted=1, o_pc_valid=0, and o_pc/o_instr_cnt stay frozen for 10 cycles despite i_pc_sel and i_stall toggling.
- Async reset mid-run: assert i_rst_n=0 between clock edges while in RUN at o_pc=0x84 -> o_pc=RESET_VECTOR and o_instr_cnt=0 immediately, without waiting for a clock edge. Reboot follows the BOOT sequence.

Source files
------------

// File: rtl/pc_reg_unit.sv
// pc_reg_unit: program-counter register stage for the single-cycle RV32I core.
// It holds the current PC and selects the next one from the sequential
// pc_four value or an ALU redirect. It also handles boot sequencing, stall,
// halt, trapping of misaligned redirect targets and a retired-instruction
// counter. Every output comes straight from a flop, so no input reaches
// o_pc, o_pc_valid or o_halted combinationally.
module pc_reg_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_four,
    input  logic [31:0] i_alu_data,
    input  logic        i_pc_sel,
    input  logic        i_stall,
    input  logic        i_halt_req,
    output logic [31:0] o_pc,
    output logic        o_pc_valid,
    output logic        o_misalign,
    output logic [31:0] o_mis_addr,
    output logic        o_halted,
    output logic [31:0] o_instr_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        valid_q,    valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] mis_addr_q, mis_addr_d;
    logic        halted_q,   halted_d;
    logic [31:0] cnt_q,      cnt_d;

    // The low two bits of a redirect target must be zero for a legal fetch.
    logic target_aligned;
    assign target_aligned = (i_alu_data[1:0] == 2'b00);

    // Next-state and next-output selection. The priority order in RUN is
    // halt, then stall, then redirect, then sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        mis_addr_d = mis_addr_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_BOOT: begin
                // BOOT lasts one clock and ignores every input. The PC
                // stays at the reset vector, which becomes the first fetch.
                state_d = ST_RUN;
                valid_d = 1'b1;
            end

            ST_RUN: begin
                if (i_halt_req) begin
                    // The halting instruction still retires.
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    cnt_d    = cnt_q + 32'd1;
                end else if (i_stall) begin
                    // Hold everything. A redirect seen now is not latched;
                    // upstream keeps i_pc_sel asserted until the stall drops.
                end else if (i_pc_sel) begin
                    cnt_d = cnt_q + 32'd1;
                    if (target_aligned) begin
                        pc_d = i_alu_data;
                    end else begin
                        pc_d       = TRAP_VECTOR;
                        mis_addr_d = i_alu_data;
                        misalign_d = 1'b1;
                    end
                end else begin
                    // Taken verbatim, so 0xFFFF_FFFC -> 0 wraps without a trap.
                    pc_d  = i_pc_four;
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_HALT: begin
                // Frozen until reset.
            end

            default: begin
                // An illegal encoding recovers through a clean boot.
                state_d  = ST_BOOT;
                pc_d     = RESET_VECTOR;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and output registers. The asynchronous reset overrides every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            mis_addr_q <= 32'h0000_0000;
            halted_q   <= 1'b0;
            cnt_q      <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            mis_addr_q <= mis_addr_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_pc        = pc_q;
    assign o_pc_valid  = valid_q;
    assign o_misalign  = misalign_q;
    assign o_mis_addr  = mis_addr_q;
    assign o_halted    = halted_q;
    assign o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_pc_reg_unit.sv
// tb_pc_reg_unit: scoreboard bench for pc_reg_unit.
// The driver applies one cycle of stimulus at each falling edge. It advances
// a behavioural model of the PC unit and queues the outputs expected after
// the next rising edge. A separate monitor pops the queue just after each
// rising edge and compares the DUT outputs against the queued values.
module tb_pc_reg_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_four;
    logic [31:0] alu_data;
    logic        pc_sel;
    logic        stall;
    logic        halt_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic        misalign;
    logic [31:0] mis_addr;
    logic        halted;
    logic [31:0] instr_cnt;

    // Stands in for the pc_four block.
    assign pc_four = pc + 32'd4;

    pc_reg_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pc_four   (pc_four),
        .i_alu_data  (alu_data),
        .i_pc_sel    (pc_sel),
        .i_stall     (stall),
        .i_halt_req  (halt_req),
        .o_pc        (pc),
        .o_pc_valid  (pc_valid),
        .o_misalign  (misalign),
        .o_mis_addr  (mis_addr),
        .o_halted    (halted),
        .o_instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic [31:0] mis_addr;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [31:0] m_pc, m_mis_addr, m_cnt;
    bit          m_booting, m_halted, m_mis;

    function automatic exp_t model_now();
        exp_t e;
        e.pc       = m_pc;
        e.valid    = !m_booting && !m_halted;
        e.mis      = m_mis;
        e.mis_addr = m_mis_addr;
        e.halted   = m_halted;
        e.cnt      = m_cnt;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = RV; m_mis_addr = 0; m_cnt = 0;
        m_booting = 1; m_halted = 0; m_mis = 0;
    endtask

    // One clock of the architectural rules.
    task automatic model_step(input bit sel, input logic [31:0] alu,
                              input bit stl, input bit hlt);
        m_mis = 0;
        if (m_booting) begin
            m_booting = 0;
        end else if (!m_halted) begin
            if (hlt) begin
                m_halted = 1;
                m_cnt    = m_cnt + 1;
            end else if (!stl) begin
                m_cnt = m_cnt + 1;
                if (!sel)            m_pc = m_pc + 4;
                else if (alu % 4 == 0) m_pc = alu;
                else begin
                    m_pc       = TV;
                    m_mis_addr = alu;
                    m_mis      = 1;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        cmp({tag, ".pc"},       pc,              e.pc);
        cmp({tag, ".valid"},    {31'd0, pc_valid}, {31'd0, e.valid});
        cmp({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
        cmp({tag, ".mis_addr"}, mis_addr,        e.mis_addr);
        cmp({tag, ".halted"},   {31'd0, halted}, {31'd0, e.halted});
        cmp({tag, ".cnt"},      instr_cnt,       e.cnt);
    endtask

    // Monitor: compares DUT outputs with the oldest expectation just after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp_all("cycle", e);
            $display("txn t=%0t pc=%08h valid=%0b mis=%0b mis_addr=%08h halted=%0b cnt=%0d",
                     $time, pc, pc_valid, misalign, mis_addr, halted, instr_cnt);
        end
    end

    // Drive one cycle starting at a falling edge, queue its expectation, and
    // return at the next falling edge.
    task automatic step(input bit sel, input logic [31:0] alu, input bit stl, input bit hlt);
        pc_sel = sel; alu_data = alu; stall = stl; halt_req = hlt;
        model_step(sel, alu, stl, hlt);
        exp_q.push_back(model_now());
        @(negedge clk);
    endtask

    // Assert reset between edges, check its immediate effect, then release
    // it at the following falling edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 cmp_all("async_reset", model_now());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pc_sel = 0; alu_data = 0; stall = 0; halt_req = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cmp_all("reset", model_now());
        rst_n = 1'b1;

        // Boot and sequential fetch: 0 for two cycles, then 4, 8, C.
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 0, 0);                      // now at 0x10
        // Aligned branch.
        step(1, 32'h200, 0, 0);
        step(0, 0, 0, 0);
        // Misaligned jump.
        step(1, 32'h123, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Stall versus redirect at 0x20.
        step(1, 32'h20, 0, 0);
        repeat (3) step(1, 32'h400, 1, 0);
        step(1, 32'h400, 0, 0);
        // Wrap past the top of memory, then halt.
        step(1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(bit'(i % 2), 32'h300 + 32'(i), bit'((i / 2) % 2), bit'(i % 3 == 0));

        // Async reset while running at 0x84.
        mid_reset();
        step(0, 0, 0, 0);
        step(1, 32'h80, 0, 0);
        step(0, 0, 0, 0);
        mid_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomised rounds, each ending with a mid-cycle reset.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 120; i++) begin
                logic [31:0] tgt;
                tgt = $urandom;
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                step($urandom_range(0, 3) == 0, tgt,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 80) == 0);
            end
            mid_reset();
        end
        step(0, 0, 0, 0);

        // Let the monitor drain the queue, within a bounded wait.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
